// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, sequencer state encoding and ALU opcodes
package uart_pkg;
  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
  localparam logic [NB_OPCODE-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OPCODE-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OPCODE-1:0] OP_AND = 6'h24;
  localparam logic [NB_OPCODE-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OPCODE-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OPCODE-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OPCODE-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OPCODE-1:0] OP_SRL = 6'h02;
endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: saturating idle counter with terminal-count pulse
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] count;
  assign o_tc = i_enable && count == LAST;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) count <= '0;
    else if (i_clear || o_tc) count <= '0;
    else if (i_enable && count != LAST) count <= count + CW'(1);
endmodule

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: collects A, B, opcode bytes from the UART, runs the ALU, returns the result byte
module uart_alu_sequencer
  import uart_pkg::*;
#(
  parameter int NB_DATA        = uart_pkg::NB_DATA,
  parameter int NB_OPCODE      = uart_pkg::NB_OPCODE,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_byte,
  output logic [NB_DATA-1:0]   o_alu_a,
  output logic [NB_DATA-1:0]   o_alu_b,
  output logic [NB_OPCODE-1:0] o_alu_op,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  state_t state, state_next;
  logic frame_wait, tc, returning;
  assign frame_wait = state == WAIT_B || state == WAIT_OP;
  assign returning  = state == EXEC || state == SEND || state == WAIT_TX;
  seq_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_rx_done || !frame_wait),
    .i_enable(frame_wait),
    .o_tc    (tc)
  );
  // a byte arriving on the terminal count wins over the timeout
  always_comb begin
    state_next = state;
    case (state)
      WAIT_A:  state_next = i_rx_done ? WAIT_B : WAIT_A;
      WAIT_B:  state_next = i_rx_done ? WAIT_OP : tc ? WAIT_A : WAIT_B;
      WAIT_OP: state_next = i_rx_done ? EXEC : tc ? WAIT_A : WAIT_OP;
      EXEC:    state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: state_next = i_tx_done ? WAIT_A : WAIT_TX;
      default: state_next = WAIT_A;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state       <= WAIT_A;
      o_tx_start  <= 1'b0;
      o_tx_byte   <= '0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_next;
      o_busy      <= state_next != WAIT_A;
      o_tx_start  <= state == EXEC;
      o_frame_err <= frame_wait && tc && !i_rx_done;
      o_overrun   <= returning && i_rx_done;
      if (state == WAIT_A && i_rx_done) o_alu_a <= i_rx_data;
      if (state == WAIT_B && i_rx_done) o_alu_b <= i_rx_data;
      if (state == WAIT_OP && i_rx_done) o_alu_op <= i_rx_data[NB_OPCODE-1:0];
      if (state == EXEC) o_tx_byte <= i_alu_result;
    end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: frame-level reference checks with a behavioural ALU and UART handshake model
module tb_uart_alu_sequencer;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_done = 1'b0, tx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic tx_start, busy, frame_err, overrun;
  logic [7:0] tx_byte, alu_a, alu_b, alu_result;
  logic [5:0] alu_op;
  int checks = 0, errors = 0;
  int n_start = 0, n_ferr = 0, n_ovr = 0;
  logic [7:0] tx_q[$];
  logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  always #5 clk = ~clk;
  uart_alu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_tx_done(tx_done), .o_tx_start(tx_start), .o_tx_byte(tx_byte),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_result(alu_result),
    .o_busy(busy), .o_frame_err(frame_err), .o_overrun(overrun)
  );
  function automatic logic [7:0] alu_ref(input logic [7:0] a, b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return 8'(sa >>> b);
      6'h02: return a >> b;
      default: return 8'h00;
    endcase
  endfunction
  assign alu_result = alu_ref(alu_a, alu_b, alu_op);
  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      tx_q.push_back(tx_byte);
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    rx_data = d;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_txb"}, tx_byte, 0);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask
  // called right after the opcode byte was taken
  task automatic expect_result(input logic [7:0] a, b, opb);
    int s0;
    logic [7:0] q;
    s0 = n_start;
    for (int i = 0; i < 6 && n_start == s0; i++) tick();
    chk("start_seen", n_start - s0, 1);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_op", alu_op, opb[5:0]);
    chk("tx_byte", tx_byte, alu_ref(a, b, opb[5:0]));
    q = tx_q.size() > 0 ? tx_q.pop_front() : ~alu_ref(a, b, opb[5:0]);
    chk("tx_order", q, alu_ref(a, b, opb[5:0]));
    repeat (3) tick();
    chk("busy_tx", busy, 1);
    chk("one_start", n_start - s0, 1);
    chk("tx_hold", tx_byte, alu_ref(a, b, opb[5:0]));
  endtask
  task automatic send_frame(input logic [7:0] a, b, opb, input int gap);
    send_byte(a);
    repeat (gap) tick();
    send_byte(b);
    repeat (gap) tick();
    send_byte(opb);
    expect_result(a, b, opb);
  endtask
  task automatic tx_finish;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("idle_after_tx", busy, 0);
  endtask
  initial begin
    int f0, o0, s0;
    #3;
    chk_zero("reset");
    tick();
    rst = 1'b0;
    tick();
    chk("reset_idle", busy, 0);
    send_frame(8'd22, 8'd18, 8'h20, 0);
    tx_finish();
    send_frame(8'd22, 8'd18, 8'h22, 0);
    tx_finish();
    send_frame(8'hF0, 8'h0F, 8'h25, 1);
    tx_finish();
    f0 = n_ferr;
    send_byte(8'h05);
    repeat (TO - 1) tick();
    chk("to_early", n_ferr - f0, 0);
    chk("to_busy", busy, 1);
    tick();
    chk("to_pulse", frame_err, 1);
    chk("to_idle", busy, 0);
    chk("to_keep_a", alu_a, 8'h05);
    tick();
    chk("to_once", n_ferr - f0, 1);
    send_frame(8'd1, 8'd2, 8'h20, 0);
    tx_finish();
    f0 = n_ferr;
    send_byte(8'h07);
    repeat (TO - 2) tick();
    send_byte(8'h09);
    repeat (3) tick();
    chk("tc_no_err", n_ferr - f0, 0);
    chk("tc_busy", busy, 1);
    send_byte(8'h20);
    expect_result(8'h07, 8'h09, 8'h20);
    tx_finish();
    send_frame(8'h11, 8'h22, 8'h26, 0);
    o0 = n_ovr;
    s0 = n_start;
    send_byte(8'h55);
    tick();
    chk("ovr_pulse", n_ovr - o0, 1);
    repeat (4) tick();
    chk("ovr_no_start", n_start - s0, 0);
    chk("ovr_still_busy", busy, 1);
    tx_finish();
    send_frame(8'h3C, 8'h02, 8'hC3, 0);
    o0 = n_ovr;
    @(negedge clk);
    rx_data = 8'h77;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    tx_done = 1'b0;
    #1;
    chk("both_ovr", n_ovr - o0, 1);
    chk("both_idle", busy, 0);
    send_frame(8'd3, 8'd4, 8'h22, 0);
    tx_finish();
    send_byte(8'h33);
    send_byte(8'h44);
    #3 rst = 1'b1;
    #1 chk_zero("rst_mid_frame");
    #2 rst = 1'b0;
    tick();
    send_frame(8'h81, 8'h01, 8'h03, 0);
    #3 rst = 1'b1;
    #1 chk_zero("rst_mid_tx");
    #2 rst = 1'b0;
    tick();
    send_frame(8'd22, 8'd18, 8'h20, 0);
    tx_finish();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b, opb;
      a = 8'($urandom);
      b = 8'($urandom);
      opb = {2'($urandom), ops[$urandom_range(0, 7)]};
      send_frame(a, b, opb, $urandom_range(0, 3));
      repeat ($urandom_range(0, 4)) tick();
      tx_finish();
    end
    chk("no_spurious_err", n_ferr, 2 - 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
